rx_decode_shift: RTL and testbench

Receive-side counterpart of the transmit path: samples the raw USB differential pair, recovers bit timing, decodes NRZI, removes stuffed bits, detects SYNC and EOP, and delivers packet bytes LSB-first to the downstream packet/AES logic inside the USB top level. It sits directly on the d_plus_in/d_minus_in pins that the transmit stage drives.

---
 rtl/usb_pkg.sv | 25 ++
 rtl/rx_bit_timer.sv | 50 +++++
 rtl/rx_decode_shift.sv | 151 +++++++++++++++
 tb/tb_rx_decode_shift.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB receive path: line-state encodings,
// receive FSM states and protocol constants.
package usb_pkg;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_SYNC    = 2'd1,
        RX_RECEIVE = 2'd2,
        RX_EOP     = 2'd3
    } rx_state_t;

    // Line states packed as {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam int         STUFF_LIMIT = 6;

    // (1,1) is an illegal line condition and is folded into SE0
    function automatic logic [1:0] norm_line(input logic [1:0] pair);
        return (pair == 2'b11) ? LINE_SE0 : pair;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Synchronizes the raw D+/D- pair and recovers a mid-bit sample strobe
// by realigning a free-running bit counter on every line-state change.
module rx_bit_timer
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus_in,
    input  logic       d_minus_in,
    output logic [1:0] line_state,
    output logic       sample_strobe
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       meta_reg;
    logic [1:0]       sync_reg;
    logic [1:0]       line_prev_reg;
    logic [1:0]       line_now;
    logic [CNT_W-1:0] cnt_reg;
    logic             line_change;

    assign line_now      = norm_line(sync_reg);
    assign line_change   = (line_now != line_prev_reg);
    assign line_state    = line_now;
    assign sample_strobe = (cnt_reg == CNT_MID);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            meta_reg      <= LINE_J;
            sync_reg      <= LINE_J;
            line_prev_reg <= LINE_J;
            cnt_reg       <= '0;
        end else begin
            meta_reg      <= {d_plus_in, d_minus_in};
            sync_reg      <= meta_reg;
            line_prev_reg <= line_now;
            if (line_change || cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_decode_shift.sv
// USB receive decoder: NRZI decode, SYNC/EOP detection, bit unstuffing and
// LSB-first byte assembly on top of the recovered sample strobe.
module rx_decode_shift
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus_in,
    input  logic       d_minus_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error
);

    logic [1:0] line_state;
    logic       sample_strobe;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus_in    (d_plus_in),
        .d_minus_in   (d_minus_in),
        .line_state   (line_state),
        .sample_strobe(sample_strobe)
    );

    rx_state_t  state_reg;
    logic [1:0] prev_jk_reg;
    logic [7:0] shift_reg;
    logic [7:0] data_reg;
    logic [2:0] bit_cnt_reg;
    logic [2:0] ones_reg;
    logic       partial_reg;
    logic       valid_reg;
    logic       active_reg;
    logic       eop_reg;
    logic       error_reg;

    logic       is_se0;
    logic       nrzi_bit;
    logic [7:0] shift_next;

    assign is_se0     = (line_state == LINE_SE0);
    assign nrzi_bit   = (line_state == prev_jk_reg);
    assign shift_next = {nrzi_bit, shift_reg[7:1]};

    assign rx_data   = data_reg;
    assign rx_valid  = valid_reg;
    assign rx_active = active_reg;
    assign rx_eop    = eop_reg;
    assign rx_error  = error_reg;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg   <= RX_IDLE;
            prev_jk_reg <= LINE_J;
            shift_reg   <= '0;
            data_reg    <= '0;
            bit_cnt_reg <= '0;
            ones_reg    <= '0;
            partial_reg <= 1'b0;
            valid_reg   <= 1'b0;
            active_reg  <= 1'b0;
            eop_reg     <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            eop_reg   <= 1'b0;
            error_reg <= 1'b0;
            if (sample_strobe) begin
                // SE0 carries no NRZI information, so only J/K update the reference
                if (!is_se0) begin
                    prev_jk_reg <= line_state;
                end
                case (state_reg)
                    RX_IDLE: begin
                        if (line_state == LINE_K) begin
                            state_reg   <= RX_SYNC;
                            shift_reg   <= shift_next;
                            bit_cnt_reg <= 3'd1;
                        end
                    end
                    RX_SYNC: begin
                        if (is_se0) begin
                            state_reg <= RX_IDLE;
                        end else begin
                            shift_reg <= shift_next;
                            if (bit_cnt_reg == 3'd7) begin
                                bit_cnt_reg <= '0;
                                ones_reg    <= '0;
                                if (shift_next == SYNC_BYTE) begin
                                    state_reg  <= RX_RECEIVE;
                                    active_reg <= 1'b1;
                                end else begin
                                    state_reg <= RX_IDLE;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    RX_RECEIVE: begin
                        if (is_se0) begin
                            partial_reg <= (bit_cnt_reg != 3'd0);
                            state_reg   <= RX_EOP;
                        end else if (ones_reg == 3'(STUFF_LIMIT)) begin
                            // Stuff position: a 0 is dropped, a 1 is a protocol violation
                            if (nrzi_bit) begin
                                error_reg  <= 1'b1;
                                active_reg <= 1'b0;
                                state_reg  <= RX_IDLE;
                            end else begin
                                ones_reg <= '0;
                            end
                        end else begin
                            ones_reg  <= nrzi_bit ? ones_reg + 3'd1 : 3'd0;
                            shift_reg <= shift_next;
                            if (bit_cnt_reg == 3'd7) begin
                                data_reg    <= shift_next;
                                valid_reg   <= 1'b1;
                                bit_cnt_reg <= '0;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    RX_EOP: begin
                        if (line_state == LINE_J) begin
                            eop_reg    <= 1'b1;
                            error_reg  <= partial_reg;
                            active_reg <= 1'b0;
                            state_reg  <= RX_IDLE;
                        end else if (line_state == LINE_K) begin
                            error_reg  <= 1'b1;
                            active_reg <= 1'b0;
                            state_reg  <= RX_IDLE;
                        end
                    end
                    default: state_reg <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_decode_shift.sv
// Bench for rx_decode_shift: NRZI/bit-stuffing packet encoder drives the line,
// observed output events are compared with events predicted from packet contents.
module tb_rx_decode_shift;

    localparam int         CPB = 8;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    localparam logic [3:0] EV_VALID = 4'd1;
    localparam logic [3:0] EV_EOP   = 4'd2;
    localparam logic [3:0] EV_ERR   = 4'd3;
    localparam logic [3:0] EV_RISE  = 4'd4;
    localparam logic [3:0] EV_FALL  = 4'd5;

    logic       tb_clk   = 1'b0;
    logic       tb_n_rst = 1'b0;
    logic [1:0] line_drive = J;
    logic       d_plus_in;
    logic       d_minus_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_eop;
    logic       rx_error;

    assign d_plus_in  = line_drive[1];
    assign d_minus_in = line_drive[0];

    always #5 tb_clk = ~tb_clk;

    rx_decode_shift #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (tb_clk),
        .n_rst     (tb_n_rst),
        .d_plus_in (d_plus_in),
        .d_minus_in(d_minus_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .rx_eop    (rx_eop),
        .rx_error  (rx_error)
    );

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  sym_q[$];
    logic [11:0] evq[$];
    logic [11:0] exp_q[$];
    logic [1:0]  tx_level = J;
    int          tx_ones  = 0;
    logic        prev_active = 1'b0;
    logic [7:0]  prev_data   = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Event recorder: turns output pulses and rx_active edges into a log
    always @(negedge tb_clk) begin
        if (!tb_n_rst) begin
            prev_active = rx_active;
            prev_data   = rx_data;
        end else begin
            if (rx_valid) begin
                evq.push_back({EV_VALID, rx_data});
                check("valid_err_excl", 32'(rx_error), 32'd0);
            end
            if (rx_eop) evq.push_back({EV_EOP, 7'd0, rx_error});
            else if (rx_error) evq.push_back({EV_ERR, 8'd0});
            if (rx_active && !prev_active) evq.push_back({EV_RISE, 8'd0});
            if (!rx_active && prev_active) evq.push_back({EV_FALL, 8'd0});
            if (rx_data != prev_data) check("data_hold", 32'(rx_valid), 32'd1);
            prev_active = rx_active;
            prev_data   = rx_data;
        end
    end

    task automatic put_bit(input logic b);
        if (!b) tx_level = (tx_level == J) ? K : J;
        sym_q.push_back(tx_level);
    endtask

    task automatic put_data_bit(input logic b, input logic stuff_en);
        put_bit(b);
        if (b) tx_ones++;
        else tx_ones = 0;
        if (stuff_en && tx_ones == 6) begin
            put_bit(1'b0);
            tx_ones = 0;
        end
    endtask

    task automatic put_byte(input logic [7:0] v, input logic stuff_en);
        for (int i = 0; i < 8; i++) put_data_bit(v[i], stuff_en);
    endtask

    task automatic start_pkt();
        logic [7:0] s;
        s = 8'h80;
        tx_ones = 0;
        for (int i = 0; i < 8; i++) put_bit(s[i]);
    endtask

    task automatic put_eop();
        sym_q.push_back(SE0);
        sym_q.push_back(SE0);
        sym_q.push_back(J);
        tx_level = J;
    endtask

    task automatic put_idle(input int n);
        for (int i = 0; i < n; i++) sym_q.push_back(J);
    endtask

    task automatic send();
        while (sym_q.size() > 0) begin
            line_drive = sym_q.pop_front();
            repeat (CPB) @(negedge tb_clk);
        end
    endtask

    task automatic compare_events(input string tag);
        $display("txn %s: %0d events observed, %0d expected", tag, evq.size(), exp_q.size());
        check({tag, "_count"}, 32'(evq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
            check($sformatf("%s_ev%0d", tag, i), 32'(evq[i]), 32'(exp_q[i]));
        end
        evq.delete();
        exp_q.delete();
    endtask

    task automatic run(input string tag);
        put_idle(4);
        send();
        compare_events(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},   32'(rx_data),   32'd0);
        check({tag, "_valid"},  32'(rx_valid),  32'd0);
        check({tag, "_active"}, 32'(rx_active), 32'd0);
        check({tag, "_eop"},    32'(rx_eop),    32'd0);
        check({tag, "_error"},  32'(rx_error),  32'd0);
    endtask

    initial begin
        repeat (3) @(posedge tb_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge tb_clk);
        #2 tb_n_rst = 1'b1;
        put_idle(4);
        send();

        // Two clean bytes
        start_pkt(); put_byte(8'hA5, 1'b1); put_byte(8'h3C, 1'b1); put_eop();
        exp_q = '{{EV_RISE, 8'h0}, {EV_VALID, 8'hA5}, {EV_VALID, 8'h3C}, {EV_EOP, 8'h0}, {EV_FALL, 8'h0}};
        run("a5_3c");

        // Stuffed 0 inside 8'hFF, ones run carries into 8'h03
        start_pkt(); put_byte(8'hFF, 1'b1); put_byte(8'h03, 1'b1); put_eop();
        exp_q = '{{EV_RISE, 8'h0}, {EV_VALID, 8'hFF}, {EV_VALID, 8'h03}, {EV_EOP, 8'h0}, {EV_FALL, 8'h0}};
        run("stuffed_ff");

        // Missing stuff bit: seventh consecutive 1
        start_pkt(); put_byte(8'hFF, 1'b0); put_eop();
        exp_q = '{{EV_RISE, 8'h0}, {EV_ERR, 8'h0}, {EV_FALL, 8'h0}};
        run("stuff_err");

        // Partial byte before EOP
        start_pkt(); put_byte(8'h12, 1'b1);
        put_data_bit(1'b1, 1'b1); put_data_bit(1'b0, 1'b1); put_data_bit(1'b1, 1'b1);
        put_eop();
        exp_q = '{{EV_RISE, 8'h0}, {EV_VALID, 8'h12}, {EV_EOP, 8'h1}, {EV_FALL, 8'h0}};
        run("partial");

        // Corrupted SYNC KJKJKKKK followed by data: nothing reported
        sym_q = '{K, J, K, J, K, K, K, K};
        tx_level = K;
        put_byte(8'h00, 1'b1); put_eop();
        run("bad_sync");
        start_pkt(); put_byte(8'h5A, 1'b1); put_eop();
        exp_q = '{{EV_RISE, 8'h0}, {EV_VALID, 8'h5A}, {EV_EOP, 8'h0}, {EV_FALL, 8'h0}};
        run("after_bad_sync");

        // One-clock reset in the middle of the second byte
        start_pkt(); put_byte(8'h96, 1'b1); put_byte(8'h69, 1'b1); put_eop(); put_idle(4);
        exp_q = '{{EV_RISE, 8'h0}, {EV_VALID, 8'h96}};
        fork
            send();
            begin
                repeat ((8 + 8 + 3) * CPB + CPB / 2) @(negedge tb_clk);
                #2 tb_n_rst = 1'b0;
                @(posedge tb_clk);
                #1;
                check_reset_outputs("mid_reset");
                @(negedge tb_clk);
                #2 tb_n_rst = 1'b1;
            end
        join
        compare_events("mid_reset_pkt");
        start_pkt(); put_byte(8'hC3, 1'b1); put_eop();
        exp_q = '{{EV_RISE, 8'h0}, {EV_VALID, 8'hC3}, {EV_EOP, 8'h0}, {EV_FALL, 8'h0}};
        run("after_reset");

        // Randomized packets: random payload, random trailing partial bits
        for (int p = 0; p < 12; p++) begin
            int         nb;
            int         np;
            logic [7:0] b;
            nb = $urandom_range(1, 3);
            np = $urandom_range(0, 3);
            start_pkt();
            exp_q.push_back({EV_RISE, 8'h0});
            for (int i = 0; i < nb; i++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                put_byte(b, 1'b1);
                exp_q.push_back({EV_VALID, b});
            end
            for (int i = 0; i < np; i++) put_data_bit(1'($urandom), 1'b1);
            put_eop();
            exp_q.push_back({EV_EOP, 7'd0, (np != 0)});
            exp_q.push_back({EV_FALL, 8'h0});
            put_idle($urandom_range(0, 4));
            run($sformatf("rand%0d", p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
